// File: rtl/dcf77_sync_ctrl_pkg.sv
// dcf77_sync_ctrl_pkg: sync states, DCF77 telegram layout, bit positions and BCD helper.
//   sync_state_t  : UNLOCKED / CANDIDATE / LOCKED / HOLDOVER
//   dcf77_frame_t : telegram bits [58:0], MSB (date parity) first
package dcf77_sync_ctrl_pkg;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        CANDIDATE = 2'd1,
        LOCKED    = 2'd2,
        HOLDOVER  = 2'd3
    } sync_state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        logic        p_date;
        bcd_t        year_t;
        bcd_t        year_o;
        logic        month_t;
        bcd_t        month_o;
        logic [2:0]  dow;
        logic [1:0]  day_t;
        bcd_t        day_o;
        logic        p_hour;
        logic [1:0]  hour_t;
        bcd_t        hour_o;
        logic        p_min;
        logic [2:0]  min_t;
        bcd_t        min_o;
        logic        time_start;
        logic [18:0] info;
        logic        start;
    } dcf77_frame_t;

    localparam int BIT_START      = 0;
    localparam int BIT_TIME_START = 20;
    localparam int BIT_P_MIN      = 28;
    localparam int BIT_P_HOUR     = 35;
    localparam int BIT_P_DATE     = 58;

    // 8 bits so an out-of-range tens digit cannot wrap back into a legal value
    function automatic logic [7:0] bcd2bin(input logic [3:0] tens, input bcd_t ones);
        return 8'(tens) * 8'd10 + 8'(ones);
    endfunction

endpackage

// File: rtl/dcf77_frame_check.sv
// dcf77_frame_check: combinational plausibility and minute-consistency check of a telegram.
//   cur        : telegram under test
//   prv        : last plausible telegram (reference)
//   plausible  : markers, parities, BCD digits and field ranges all valid
//   consistent : plausible and exactly one minute after prv
module dcf77_frame_check
    import dcf77_sync_ctrl_pkg::*;
(
    input  dcf77_frame_t cur,
    input  dcf77_frame_t prv,
    output logic         plausible,
    output logic         consistent
);

    logic [58:0] b, rb;
    logic [7:0]  min, hour, day, mon, pmin, phour, exp_min, exp_hour;
    logic        nib_ok, range_ok, min_wrap, unused;

    assign b  = cur;
    assign rb = prv;

    assign min   = bcd2bin(4'(cur.min_t), cur.min_o);
    assign hour  = bcd2bin(4'(cur.hour_t), cur.hour_o);
    assign day   = bcd2bin(4'(cur.day_t), cur.day_o);
    assign mon   = bcd2bin(4'(cur.month_t), cur.month_o);
    assign pmin  = bcd2bin(4'(prv.min_t), prv.min_o);
    assign phour = bcd2bin(4'(prv.hour_t), prv.hour_o);

    assign nib_ok = cur.min_o <= 4'd9 && cur.hour_o <= 4'd9 && cur.day_o <= 4'd9 &&
                    cur.month_o <= 4'd9 && cur.year_t <= 4'd9 && cur.year_o <= 4'd9;

    assign range_ok = min <= 8'd59 && hour <= 8'd23 && day >= 8'd1 && day <= 8'd31 &&
                      cur.dow != 3'd0 && mon >= 8'd1 && mon <= 8'd12;

    assign plausible = !b[BIT_START] && b[BIT_TIME_START] &&
                       !(^b[BIT_P_MIN:BIT_TIME_START+1]) &&
                       !(^b[BIT_P_HOUR:BIT_P_MIN+1]) &&
                       !(^b[BIT_P_DATE:BIT_P_HOUR+1]) &&
                       nib_ok && range_ok;

    assign min_wrap = pmin == 8'd59;
    assign exp_min  = min_wrap ? 8'd0 : pmin + 8'd1;
    assign exp_hour = !min_wrap ? phour : phour == 8'd23 ? 8'd0 : phour + 8'd1;

    // on 23:59 -> 00:00 the date may change arbitrarily (month/year ends)
    assign consistent = plausible && min == exp_min && hour == exp_hour &&
                        ((min_wrap && phour == 8'd23) ||
                         b[BIT_P_DATE-1:BIT_P_HOUR+1] == rb[BIT_P_DATE-1:BIT_P_HOUR+1]);

    assign unused = ^{b[BIT_TIME_START-1:BIT_START+1], rb[BIT_P_DATE], rb[BIT_P_HOUR:0]};

endmodule

// File: rtl/dcf77_sync_ctrl.sv
// dcf77_sync_ctrl: qualifies DCF77 telegrams and sequences loading of the time-of-day clock.
//   clk, rst     : system clock, asynchronous active-high reset
//   clk_en       : 10 ms tick
//   frame_valid  : telegram strobe; frame and frame_error are sampled with it
//   load         : one-clk load pulse, two clocks after the accepted frame_valid
//   locked       : high in LOCKED or HOLDOVER
//   state        : current sync_state_t
//   good_cnt     : plausible telegrams (saturating)
//   bad_cnt      : rejected telegrams (saturating)
module dcf77_sync_ctrl
    import dcf77_sync_ctrl_pkg::*;
#(
    parameter int CONFIRM_FRAMES = 2,
    parameter int TICKS_PER_MIN  = 6000,
    parameter int FRAME_TIMEOUT  = 6100,
    parameter int HOLDOVER_MIN   = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        frame_valid,
    input  logic        frame_error,
    input  logic [58:0] frame,
    output logic        load,
    output logic        locked,
    output sync_state_t state,
    output logic [7:0]  good_cnt,
    output logic [7:0]  bad_cnt
);

    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam int PW = $clog2(TICKS_PER_MIN + 1);
    localparam int MW = $clog2(HOLDOVER_MIN + 1);

    dcf77_frame_t cap_frame, ref_frame;
    sync_state_t  state_n;
    logic         cap_err, v1, v2, accept, plaus, cons, plaus_r, cons_r;
    logic         to_expire, hold_expire, cand;
    logic [2:0]   confirm, confirm_n;
    logic [3:0]   step;
    logic [TW-1:0] to_cnt;
    logic [PW-1:0] pre;
    logic [MW-1:0] hmin;

    // a new telegram is ignored while one is still in the pipeline
    assign accept = frame_valid && !v1 && !v2;

    dcf77_frame_check u_check (
        .cur        (cap_frame),
        .prv        (ref_frame),
        .plausible  (plaus),
        .consistent (cons)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            cap_frame <= '0;
            cap_err <= 1'b0;
            plaus_r <= 1'b0;
            cons_r <= 1'b0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            if (accept) begin
                cap_frame <= dcf77_frame_t'(frame);
                cap_err <= frame_error;
            end
            if (v1) begin
                plaus_r <= plaus && !cap_err;
                cons_r <= cons && !cap_err;
            end
        end
    end

    // a frame_valid in the expiry cycle clears the counter, so the frame wins
    assign to_expire   = clk_en && !frame_valid && to_cnt == TW'(FRAME_TIMEOUT - 1);
    assign hold_expire = clk_en && pre == PW'(TICKS_PER_MIN - 1) && hmin == MW'(HOLDOVER_MIN - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            pre <= '0;
            hmin <= '0;
        end else begin
            to_cnt <= (frame_valid || state != LOCKED) ? '0 : clk_en ? to_cnt + TW'(1) : to_cnt;
            pre <= (state != HOLDOVER) ? '0 : !clk_en ? pre : pre == PW'(TICKS_PER_MIN - 1) ? '0 : pre + PW'(1);
            hmin <= (state != HOLDOVER) ? '0 : (clk_en && pre == PW'(TICKS_PER_MIN - 1)) ? hmin + MW'(1) : hmin;
        end
    end

    // HOLDOVER with a started confirmation run behaves exactly like CANDIDATE
    assign cand = state == CANDIDATE || (state == HOLDOVER && confirm != 3'd0);
    assign step = {1'b0, confirm} + 4'd1;

    always_comb begin
        state_n = state;
        confirm_n = confirm;
        load = 1'b0;
        if (v2) begin
            case (state)
                UNLOCKED: begin
                    if (plaus_r) begin
                        state_n = CANDIDATE;
                        confirm_n = 3'd1;
                    end
                end
                LOCKED: begin
                    if (cons_r) begin
                        load = 1'b1;
                    end else begin
                        state_n = HOLDOVER;
                        confirm_n = 3'd0;
                    end
                end
                default: begin
                    if (cand && cons_r && step >= 4'(CONFIRM_FRAMES)) begin
                        state_n = LOCKED;
                        confirm_n = 3'd0;
                        load = 1'b1;
                    end else if (cand && cons_r) begin
                        confirm_n = step[2:0];
                    end else if (plaus_r) begin
                        confirm_n = 3'd1;
                    end else begin
                        state_n = (state == CANDIDATE) ? UNLOCKED : HOLDOVER;
                        confirm_n = 3'd0;
                    end
                end
            endcase
        end else if (state == LOCKED && to_expire) begin
            state_n = HOLDOVER;
            confirm_n = 3'd0;
        end else if (state == HOLDOVER && hold_expire) begin
            state_n = UNLOCKED;
            confirm_n = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= UNLOCKED;
            confirm <= 3'd0;
            good_cnt <= 8'd0;
            bad_cnt <= 8'd0;
            ref_frame <= '0;
        end else begin
            state <= state_n;
            confirm <= confirm_n;
            if (v2 && plaus_r) begin
                ref_frame <= cap_frame;
                good_cnt <= (good_cnt == 8'hFF) ? good_cnt : good_cnt + 8'd1;
            end
            if (v2 && !plaus_r)
                bad_cnt <= (bad_cnt == 8'hFF) ? bad_cnt : bad_cnt + 8'd1;
        end
    end

    assign locked = state == LOCKED || state == HOLDOVER;

endmodule
